lna_seq: RTL and testbench

LNA_SEQ -- requirements
Module: lna_seq

---
 rtl/lna_seq_pkg.sv | 26 ++
 rtl/lna_seq.sv | 122 ++++++++++++
 tb/tb_lna_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lna_seq_pkg.sv
// rtl/lna_seq_pkg.sv - shared LNA defines: mode width, sequencer state encoding, register addresses
package lna_seq_pkg;

    // Width of the analog gain-mode bus
    localparam int unsigned LNA_MODE_W = 3;

    // Width of the settle/guard down-counter and the switch counter
    localparam int unsigned LNA_CNT_W  = 8;

    // LNA register block address map
    localparam logic [7:0] LNA_REG_CTRL_ADDR   = 8'h00;
    localparam logic [7:0] LNA_REG_MODE_ADDR   = 8'h04;
    localparam logic [7:0] LNA_REG_STATUS_ADDR = 8'h08;
    localparam logic [7:0] LNA_REG_SWCNT_ADDR  = 8'h0C;

    // Power sequencer states
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ON     = 2'd2,
        ST_SWITCH = 2'd3
    } lna_state_e;

    typedef logic [LNA_MODE_W-1:0] lna_mode_t;

endpackage

// File: rtl/lna_seq.sv
// rtl/lna_seq.sv - LNA power-up / gain-mode switch sequencer
module lna_seq
    import lna_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned GUARD_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pd_req,
    input  logic [LNA_MODE_W-1:0] mode_req,
    output logic                  lna_pd,
    output logic [LNA_MODE_W-1:0] lna_mode,
    output logic                  lna_on,
    output logic                  busy,
    output logic [LNA_CNT_W-1:0]  sw_cnt
);

    localparam logic [LNA_CNT_W-1:0] SETTLE_LOAD = LNA_CNT_W'(SETTLE_CYC - 1);
    localparam logic [LNA_CNT_W-1:0] GUARD_LOAD  = LNA_CNT_W'(GUARD_CYC - 1);

    lna_state_e            state_q, state_d;
    logic [LNA_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  lna_pd_q, lna_pd_d;
    lna_mode_t             lna_mode_q, lna_mode_d;
    logic                  lna_on_q, lna_on_d;
    logic                  busy_q, busy_d;
    logic [LNA_CNT_W-1:0]  sw_cnt_q, sw_cnt_d;

    // Next-state and registered-output logic; power-down request overrides everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lna_pd_d   = lna_pd_q;
        lna_mode_d = lna_mode_q;
        lna_on_d   = lna_on_q;
        busy_d     = busy_q;
        sw_cnt_d   = sw_cnt_q;

        if (pd_req) begin
            state_d  = ST_OFF;
            lna_pd_d = 1'b1;
            lna_on_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d    = ST_WAKE;
                    lna_mode_d = mode_req;
                    lna_pd_d   = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = SETTLE_LOAD;
                end
                ST_WAKE: begin
                    // mode_req is deliberately not looked at until settled
                    if (cnt_q == '0) begin
                        state_d  = ST_ON;
                        lna_on_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_ON: begin
                    if (mode_req != lna_mode_q) begin
                        state_d  = ST_SWITCH;
                        lna_pd_d = 1'b1;
                        lna_on_d = 1'b0;
                        busy_d   = 1'b1;
                        cnt_d    = GUARD_LOAD;
                    end
                end
                ST_SWITCH: begin
                    // A switch always completes once started, even if mode_req reverts
                    if (cnt_q == '0) begin
                        state_d    = ST_WAKE;
                        lna_mode_d = mode_req;
                        lna_pd_d   = 1'b0;
                        cnt_d      = SETTLE_LOAD;
                        sw_cnt_d   = sw_cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    lna_pd_d = 1'b1;
                    lna_on_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous power-on defaults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            lna_pd_q   <= 1'b1;
            lna_mode_q <= '0;
            lna_on_q   <= 1'b0;
            busy_q     <= 1'b0;
            sw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lna_pd_q   <= lna_pd_d;
            lna_mode_q <= lna_mode_d;
            lna_on_q   <= lna_on_d;
            busy_q     <= busy_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign lna_pd   = lna_pd_q;
    assign lna_mode = lna_mode_q;
    assign lna_on   = lna_on_q;
    assign busy     = busy_q;
    assign sw_cnt   = sw_cnt_q;

endmodule

// File: tb/tb_lna_seq.sv
// tb/tb_lna_seq.sv - randomized self-checking bench for lna_seq against a deadline-based model
module tb_lna_seq;

    localparam int S = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pd_req = 1'b1;
    logic [2:0] mode_req = 3'd0;
    logic       lna_pd;
    logic [2:0] lna_mode;
    logic       lna_on;
    logic       busy;
    logic [7:0] sw_cnt;

    always #5 clk = ~clk;

    lna_seq #(.SETTLE_CYC(S), .GUARD_CYC(G)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pd_req   (pd_req),
        .mode_req (mode_req),
        .lna_pd   (lna_pd),
        .lna_mode (lna_mode),
        .lna_on   (lna_on),
        .busy     (busy),
        .sw_cnt   (sw_cnt)
    );

    int total = 0;
    int bad = 0;

    // Model: phase plus an absolute edge number at which the current timed phase ends
    localparam int P_OFF = 0, P_WAKE = 1, P_ON = 2, P_SW = 3;
    int         ph;
    int         e;
    int         t_end;
    logic       m_pd;
    logic [2:0] m_mode;
    logic       m_on;
    logic       m_busy;
    int         m_sw;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic model_reset();
        ph = P_OFF; e = 0; t_end = 0;
        m_pd = 1'b1; m_mode = 3'd0; m_on = 1'b0; m_busy = 1'b0; m_sw = 0;
    endtask

    task automatic model_edge();
        e++;
        if (pd_req) begin
            ph = P_OFF; m_pd = 1'b1; m_on = 1'b0; m_busy = 1'b0;
        end else if (ph == P_OFF) begin
            ph = P_WAKE; m_mode = mode_req; m_pd = 1'b0; m_busy = 1'b1; t_end = e + S;
        end else if (ph == P_WAKE) begin
            if (e == t_end) begin
                ph = P_ON; m_on = 1'b1; m_busy = 1'b0;
            end
        end else if (ph == P_ON) begin
            if (mode_req != m_mode) begin
                ph = P_SW; m_pd = 1'b1; m_on = 1'b0; m_busy = 1'b1; t_end = e + G;
            end
        end else begin
            if (e == t_end) begin
                ph = P_WAKE; m_mode = mode_req; m_pd = 1'b0; t_end = e + S;
                m_sw = (m_sw + 1) % 256;
            end
        end
    endtask

    task automatic compare_all();
        chk("lna_pd", int'(lna_pd), int'(m_pd));
        chk("lna_mode", int'(lna_mode), int'(m_mode));
        chk("lna_on", int'(lna_on), int'(m_on));
        chk("busy", int'(busy), int'(m_busy));
        chk("sw_cnt", int'(sw_cnt), m_sw);
        if (lna_on) begin
            chk("inv_on_pd", int'(lna_pd), 0);
            chk("inv_on_busy", int'(busy), 0);
        end
    endtask

    // One clock: model follows the same edge the DUT saw, then outputs are compared 1ns later
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int guard;
        int prev;
        model_reset();
        pd_req = 1'b0;
        mode_req = 3'd3;
        tick();
        tick();
        chk("rst_pd", int'(lna_pd), 1);
        chk("rst_mode", int'(lna_mode), 0);
        chk("rst_busy", int'(busy), 0);

        // Reset release with mode 3
        rst_n = 1'b1;
        tick();
        chk("wake_pd", int'(lna_pd), 0);
        chk("wake_mode", int'(lna_mode), 3);
        chk("wake_busy", int'(busy), 1);
        repeat (3) begin
            tick();
            chk("wake_busy_hold", int'(busy), 1);
            chk("wake_on_low", int'(lna_on), 0);
        end
        tick();
        chk("on_after_5", int'(lna_on), 1);
        chk("on_busy", int'(busy), 0);

        // Mode switch 3 -> 5
        mode_req = 3'd5;
        tick();
        chk("sw_pd1", int'(lna_pd), 1);
        tick();
        chk("sw_pd2", int'(lna_pd), 1);
        tick();
        chk("sw_exit_pd", int'(lna_pd), 0);
        chk("sw_exit_mode", int'(lna_mode), 5);
        chk("sw_exit_cnt", int'(sw_cnt), 1);
        repeat (3) tick();
        chk("sw_on_early", int'(lna_on), 0);
        tick();
        chk("sw_on", int'(lna_on), 1);

        // mode_req toggles 5->6->5 inside SWITCH
        mode_req = 3'd6;
        tick();
        mode_req = 3'd5;
        tick();
        tick();
        chk("toggle_mode", int'(lna_mode), 5);
        chk("toggle_cnt", int'(sw_cnt), 2);
        repeat (4) tick();
        chk("toggle_on", int'(lna_on), 1);

        // Power-down during WAKE with cnt=2
        mode_req = 3'd1;
        repeat (4) tick();
        pd_req = 1'b1;
        tick();
        chk("pd_pd", int'(lna_pd), 1);
        chk("pd_on", int'(lna_on), 0);
        chk("pd_busy", int'(busy), 0);
        chk("pd_mode", int'(lna_mode), 1);
        pd_req = 1'b0;
        repeat (6) tick();

        // Asynchronous reset mid-SWITCH
        mode_req = 3'd2;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_pd", int'(lna_pd), 1);
        chk("arst_mode", int'(lna_mode), 0);
        chk("arst_on", int'(lna_on), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sw", int'(sw_cnt), 0);
        model_reset();
        tick();
        rst_n = 1'b1;

        // 256 completed switches wrap sw_cnt back to 0
        for (int i = 0; i < 256; i++) begin
            guard = 0;
            while (ph != P_ON && guard < 50) begin tick(); guard++; end
            if (guard >= 50) chk("wrap_wait_on", guard, -1);
            mode_req = m_mode + 3'd1 + 3'($urandom_range(0, 6));
            prev = m_sw;
            guard = 0;
            while (m_sw == prev && guard < 50) begin tick(); guard++; end
            if (guard >= 50) chk("wrap_wait_sw", guard, -1);
        end
        chk("wrap_zero", int'(sw_cnt), 0);

        // Random traffic with occasional power-down and async reset pulses
        for (int c = 0; c < 3000; c++) begin
            pd_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 5) == 0) mode_req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
